rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_arb_pkg.sv | 23 ++
 rtl/rf_arb_fifo.sv | 71 +++++++
 rtl/rf_write_arbiter.sv | 127 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file write arbiter.
//   wr_req_t : one register write {addr, data} at the default widths
//   grant_e  : which requester owns the write port in a given cycle
//   STARVE_LIMIT_DEFAULT : default wait, in cycles, before a queued secondary
//                          write is forced past the primary stream
package rf_arb_pkg;

  localparam int unsigned RF_ADDR_W_DEFAULT    = 5;
  localparam int unsigned RF_DATA_W_DEFAULT    = 32;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  typedef struct packed {
    logic [RF_ADDR_W_DEFAULT-1:0] addr;
    logic [RF_DATA_W_DEFAULT-1:0] data;
  } wr_req_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_WB   = 2'd1,
    GRANT_MC   = 2'd2
  } grant_e;

endpackage

// File: rtl/rf_arb_fifo.sv
// Two-entry in-order queue for secondary write requests.
// Ports:
//   iClk, iRstN   clock, asynchronous active-low reset (clears the queue)
//   push, din     enqueue din; ignored while full, even if pop is also set
//   pop           dequeue the head; ignored while empty
//   full, empty   occupancy flags (registered state)
//   head          oldest entry; only meaningful while !empty
// entry_t lets the parent store a request struct sized to its own widths.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter type entry_t = wr_req_t
) (
  input  logic   iClk,
  input  logic   iRstN,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push_ok, pop_ok;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates one register-file write port between the pipeline writeback
// (primary) and a multi-cycle unit (secondary, buffered in a 2-entry queue).
// Ports:
//   iClk, iRstN                      clock, asynchronous active-low reset
//   iWbValid/iWbAddr/iWbData         primary request; oWbStall holds it off
//   iMcValid/iMcAddr/iMcData         secondary request; accepted when oMcReady
//   oWriteEn/oWriteAddress/oWriteData registered write, one cycle after grant
// Build option RF_ARB_STARVE_GUARD_EN: a queued secondary write that has been
// passed over STARVE_LIMIT times preempts the primary (which then stalls).
// Without it the primary has strict priority and never stalls.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = RF_ADDR_W_DEFAULT,
  parameter int unsigned DATA_WIDTH    = RF_DATA_W_DEFAULT,
  parameter int unsigned STARVE_LIMIT  = STARVE_LIMIT_DEFAULT
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic                     iWbValid,
  input  logic [ADDRESS_WIDTH-1:0] iWbAddr,
  input  logic [DATA_WIDTH-1:0]    iWbData,
  output logic                     oWbStall,
  input  logic                     iMcValid,
  input  logic [ADDRESS_WIDTH-1:0] iMcAddr,
  input  logic [DATA_WIDTH-1:0]    iMcData,
  output logic                     oMcReady,
  output logic                     oWriteEn,
  output logic [ADDRESS_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0]    oWriteData
);

  if (ADDRESS_WIDTH < 1 || DATA_WIDTH < 1 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("rf_write_arbiter: widths and STARVE_LIMIT must be at least 1");
  end

  // Same layout as wr_req_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } req_t;

  req_t   mc_req, wb_req, head, grant_req;
  logic   fifo_full, fifo_empty, mc_push, head_due;
  grant_e grant;

  logic                     wr_en_q, wr_en_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve_q, starve_d;
`endif

  rf_arb_fifo #(.entry_t(req_t)) u_fifo (
    .iClk  (iClk),
    .iRstN (iRstN),
    .push  (mc_push),
    .pop   (grant == GRANT_MC),
    .din   (mc_req),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  always_comb begin
    mc_req    = '{addr: iMcAddr, data: iMcData};
    wb_req    = '{addr: iWbAddr, data: iWbData};
    oMcReady  = !fifo_full;
    mc_push   = iMcValid && !fifo_full;
`ifdef RF_ARB_STARVE_GUARD_EN
    head_due  = !fifo_empty && (!iWbValid || starve_q == STARVE_W'(STARVE_LIMIT));
`else
    head_due  = !fifo_empty && !iWbValid;
`endif
    grant     = GRANT_NONE;
    grant_req = wb_req;
    if (head_due) begin
      grant     = GRANT_MC;
      grant_req = head;
    end else if (iWbValid) begin
      grant     = GRANT_WB;
    end
`ifdef RF_ARB_STARVE_GUARD_EN
    oWbStall  = iWbValid && (grant == GRANT_MC);
    starve_d  = '0;
    if (!fifo_empty && grant != GRANT_MC) begin
      starve_d = (starve_q == STARVE_W'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
    end
`else
    oWbStall  = 1'b0;
`endif
    // Address 0 is hardwired: the grant is consumed but nothing is written,
    // and the visible address/data keep the last real write.
    wr_en_d   = (grant != GRANT_NONE) && (grant_req.addr != '0);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_en_d) begin
      wr_addr_d = grant_req.addr;
      wr_data_d = grant_req.data;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef RF_ARB_STARVE_GUARD_EN
      starve_q  <= '0;
`endif
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef RF_ARB_STARVE_GUARD_EN
      starve_q  <= starve_d;
`endif
    end
  end

  assign oWriteEn      = wr_en_q;
  assign oWriteAddress = wr_addr_q;
  assign oWriteData    = wr_data_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0, mc_valid = 1'b0;
  logic [4:0]  wb_addr = '0, mc_addr = '0;
  logic [31:0] wb_data = '0, mc_data = '0;
  logic        wb_stall, mc_ready, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .iClk          (clk),
    .iRstN         (rst_n),
    .iWbValid      (wb_valid),
    .iWbAddr       (wb_addr),
    .iWbData       (wb_data),
    .oWbStall      (wb_stall),
    .iMcValid      (mc_valid),
    .iMcAddr       (mc_addr),
    .iMcData       (mc_data),
    .oMcReady      (mc_ready),
    .oWriteEn      (wr_en),
    .oWriteAddress (wr_addr),
    .oWriteData    (wr_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  // Reference model: secondary queue, starve count, and expected writes.
  wr_t         mq[$];
  wr_t         exp_q[$];
  int          starve = 0;
  logic [4:0]  last_a = '0;
  logic [31:0] last_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    starve = 0;
    last_a = '0;
    last_d = '0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model,
  // then check the registered write port after the edge.
  task automatic step(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      output logic stall_seen, output logic ready_seen);
    logic exp_ready, head_g, exp_stall, any_g;
    wr_t  g, e;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    mc_valid = mv; mc_addr = ma; mc_data = md;
    #2;
    exp_ready = (mq.size() < 2);
    head_g    = (mq.size() > 0) && (!wv || (GUARD && starve == LIMIT));
    exp_stall = GUARD && wv && head_g;
    chk("mc_ready", mc_ready, exp_ready);
    chk("wb_stall", wb_stall, exp_stall);
    stall_seen = wb_stall;
    ready_seen = mc_ready;
    any_g = head_g || wv;
    if (head_g) g = mq[0];
    else        g = '{a: wa, d: wd};
    if (any_g && g.a != 5'd0) begin
      exp_q.push_back(g);
      last_a = g.a;
      last_d = g.d;
    end
    if (GUARD) begin
      if (mq.size() > 0 && !head_g) starve = (starve == LIMIT) ? LIMIT : starve + 1;
      else                          starve = 0;
    end
    if (head_g) void'(mq.pop_front());
    if (mv && exp_ready) mq.push_back('{a: ma, d: md});
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_wr_en", wr_en, 1'b1);
      chk("sb_wr_addr", wr_addr, e.a);
      chk("sb_wr_data", wr_data, e.d);
    end else begin
      chk("sb_idle_en", wr_en, 1'b0);
      chk("sb_hold_addr", wr_addr, last_a);
      chk("sb_hold_data", wr_data, last_d);
    end
  endtask

  task automatic idle(output logic s, output logic r);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, s, r);
  endtask

  typedef struct {
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        x_stall;
    logic        x_ready;
    logic        x_en;
    logic [4:0]  x_a;
    logic [31:0] x_d;
  } vec_t;

  vec_t vt[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s, r;
    int   first_stall, n_stall, k, saw9;

    // Fresh queue after reset for every vector sequence below.
    vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF};
    vt[1] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF};
    vt[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF};
    vt[3] = '{1'b1, 5'd31, 32'h00000001, 1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b1, 5'd31, 32'h00000001};
    vt[4] = '{1'b1, 5'd3,  32'hA5A5A5A5, 1'b1, 5'd12, 32'h55, 1'b0, 1'b1, 1'b1, 5'd3,  32'hA5A5A5A5};
    vt[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b1, 5'd12, 32'h55};
    vt[6] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b0, 5'd12, 32'h55};

    // Reset values
    #3;
    chk("rst_en", wr_en, 1'b0);
    chk("rst_addr", wr_addr, 5'd0);
    chk("rst_data", wr_data, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready", mc_ready, 1'b1);
    chk("rel_en", wr_en, 1'b0);

    for (int i = 0; i < 7; i++) begin
      step(vt[i].wv, vt[i].wa, vt[i].wd, vt[i].mv, vt[i].ma, vt[i].md, s, r);
      chk($sformatf("vec%0d_stall", i), s, vt[i].x_stall);
      chk($sformatf("vec%0d_ready", i), r, vt[i].x_ready);
      chk($sformatf("vec%0d_en", i), wr_en, vt[i].x_en);
      chk($sformatf("vec%0d_addr", i), wr_addr, vt[i].x_a);
      chk($sformatf("vec%0d_data", i), wr_data, vt[i].x_d);
    end

    // Two secondary pushes with primary idle: 7 then 8 on consecutive cycles.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h70, s, r);
    chk("s2_push_en", wr_en, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h80, s, r);
    chk("s2_addr7", wr_addr, 5'd7);
    chk("s2_en7", wr_en, 1'b1);
    idle(s, r);
    chk("s2_addr8", wr_addr, 5'd8);
    chk("s2_data8", wr_data, 32'h80);
    idle(s, r);

    // Secondary 9 queued behind a continuously valid primary.
    step(1'b1, 5'd16, 32'h160, 1'b1, 5'd9, 32'h99, s, r);
    first_stall = -1;
    n_stall = 0;
    saw9 = -1;
    k = 1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5'(16 + k), 32'h160 + k, 1'b0, 5'd0, 32'd0, s, r);
      if (s) begin
        n_stall++;
        if (first_stall < 0) first_stall = i;
      end else begin
        k++;
      end
      if (wr_en && wr_addr == 5'd9 && saw9 < 0) saw9 = i;
    end
    chk("starve_stall_cnt", n_stall, GUARD ? 1 : 0);
    chk("starve_first_stall", first_stall, GUARD ? 4 : -1);
    chk("starve_write9_at", saw9, GUARD ? 4 : -1);
    idle(s, r);
    if (!GUARD) begin
      chk("drain_en9", wr_en, 1'b1);
      chk("drain_addr9", wr_addr, 5'd9);
      chk("drain_data9", wr_data, 32'h99);
    end
    idle(s, r);

    // Fill the queue, then reset with an in-flight primary write.
    step(1'b1, 5'd21, 32'h21, 1'b1, 5'd10, 32'hA, s, r);
    step(1'b1, 5'd22, 32'h22, 1'b1, 5'd11, 32'hB, s, r);
    chk("full_ready", mc_ready, 1'b0);
    wb_valid = 1'b1;
    mc_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    wb_valid = 1'b0;
    mc_valid = 1'b0;
    #1;
    chk("mid_rst_en", wr_en, 1'b0);
    chk("mid_rst_addr", wr_addr, 5'd0);
    chk("mid_rst_data", wr_data, 32'd0);
    chk("mid_rst_ready", mc_ready, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle(s, r);
    chk("post_rst_ready", r, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
